// File: rtl/rca_checker.sv
// rca_checker: exhaustive on-board checker for a WIDTH-bit ripple-carry adder.
// Optional first-failure capture is enabled by defining RCA_CHK_FIRST_FAIL_EN.
module rca_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             c_in_o,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             c_out_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2*WIDTH:0] fail_vec,
  output logic [WIDTH:0]   fail_obs
);

  localparam int VW = 2*WIDTH+1;
  localparam int SW = $clog2(SETTLE+1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t         state;
  logic [VW-1:0]  vec;
  logic [SW-1:0]  scnt;
  logic [WIDTH:0] expected;
  logic [WIDTH:0] observed;
  logic           mismatch;
  logic           launch;
  logic [ERR_W-1:0] err_nxt;

  assign expected = {1'b0, a_o} + {1'b0, b_o}
                  + {{WIDTH{1'b0}}, c_in_o};
  assign observed = {c_out_i, sum_i};
  assign mismatch = observed != expected;
  assign launch   = start &&
                    (state == S_IDLE || state == S_DONE);

  // Saturate so a badly broken adder never wraps back to a pass.
  assign err_nxt = (mismatch && err_cnt != '1)
                 ? err_cnt + ERR_W'(1) : err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      vec     <= '0;
      scnt    <= '0;
      a_o     <= '0;
      b_o     <= '0;
      c_in_o  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (launch) begin
            state   <= S_DRIVE;
            vec     <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b1;
          end
        end
        S_DRIVE: begin
          {a_o, b_o, c_in_o} <= vec;
          scnt  <= '0;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (scnt == SW'(SETTLE-1))
            state <= S_CHECK;
          else
            scnt <= scnt + SW'(1);
        end
        S_CHECK: begin
          err_cnt <= err_nxt;
          if (vec == '1) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end else begin
            vec   <= vec + VW'(1);
            state <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RCA_CHK_FIRST_FAIL_EN
  // err_cnt==0 marks the first mismatch; it never returns to 0 mid-run.
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      fail_vec <= '0;
      fail_obs <= '0;
    end else if (state == S_CHECK && mismatch &&
                 err_cnt == '0) begin
      fail_vec <= {a_o, b_o, c_in_o};
      fail_obs <= observed;
    end
  end
`else
  assign fail_vec = '0;
  assign fail_obs = '0;
`endif

endmodule

// File: tb/tb_rca_checker.sv
// tb_rca_checker: random/faulted adder runs checked every cycle
// against a timeline model derived from run length arithmetic.
module tb_rca_checker;
  localparam int W = 4;
  localparam int S = 2;
  localparam int N = 512;
  localparam int P = S + 2;
  localparam int T = N * P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int fmode = 0;
  bit rnd_bad[N];
  logic [4:0] rnd_x[N];
  int pre[N+1];
  int first_bad = -1;

  // External adder under test, with selectable faults.
  function automatic logic [4:0] adder(int mode, int k);
    int s;
    logic [4:0] r;
    s = ((k >> 5) & 15) + ((k >> 1) & 15) + (k & 1);
    r = 5'(s);
    case (mode)
      1: r[0] = 1'b0;
      2: r[4] = 1'b0;
      3: r[3:0] = ~r[3:0];
      4: if (rnd_bad[k]) r = r ^ rnd_x[k];
      default: ;
    endcase
    return r;
  endfunction

  logic [3:0] a8, b8, sum8, a4, b4, sum4;
  logic ci8, co8, ci4, co4;
  logic busy8, done8, pass8, busy4, done4, pass4;
  logic [7:0] err8;
  logic [3:0] err4;
  logic [8:0] fv8, fv4;
  logic [4:0] fo8, fo4;

  assign {co8, sum8} = adder(fmode, int'({a8, b8, ci8}));
  assign {co4, sum4} = adder(fmode, int'({a4, b4, ci4}));

  rca_checker #(.WIDTH(W), .SETTLE(S), .ERR_W(8)) u8 (
    .clk(clk), .rst(rst), .start(start),
    .a_o(a8), .b_o(b8), .c_in_o(ci8),
    .sum_i(sum8), .c_out_i(co8),
    .busy(busy8), .done(done8), .pass(pass8),
    .err_cnt(err8), .fail_vec(fv8), .fail_obs(fo8)
  );

  rca_checker #(.WIDTH(W), .SETTLE(S), .ERR_W(4)) u4 (
    .clk(clk), .rst(rst), .start(start),
    .a_o(a4), .b_o(b4), .c_in_o(ci4),
    .sum_i(sum4), .c_out_i(co4),
    .busy(busy4), .done(done4), .pass(pass4),
    .err_cnt(err4), .fail_vec(fv4), .fail_obs(fo4)
  );

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Timeline model: edges since the accepted start.
  bit m_valid = 1'b0;
  bit m_active = 1'b0;
  int m_cyc = 0;
  int m_base = 0;

  function automatic int exp_vec();
    int k;
    if (!m_active) return 0;
    if (m_cyc == 0) return m_base;
    k = (m_cyc - 1) / P;
    return (k > N - 1) ? N - 1 : k;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b1;
      m_active <= 1'b0;
      m_cyc    <= 0;
      m_base   <= 0;
    end else if (start && !(m_active && m_cyc < T)) begin
      m_active <= 1'b1;
      m_cyc    <= 0;
      m_base   <= exp_vec();
    end else if (m_active && m_cyc < T) begin
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    int nchk, ev, ebusy, edone, epass, e8, e4, efv, efo;
    if (m_valid) begin
      nchk = 0; ev = 0; ebusy = 0; edone = 0; epass = 0;
      efv = 0; efo = 0;
      if (m_active) begin
        nchk = m_cyc / P;
        if (nchk > N) nchk = N;
        ev = exp_vec();
        ebusy = (m_cyc < T) ? 1 : 0;
        edone = 1 - ebusy;
        epass = (edone == 1 && pre[N] == 0) ? 1 : 0;
`ifdef RCA_CHK_FIRST_FAIL_EN
        if (first_bad >= 0 && first_bad < nchk) begin
          efv = first_bad;
          efo = int'(adder(fmode, first_bad));
        end
`endif
      end
      e8 = (pre[nchk] > 255) ? 255 : pre[nchk];
      e4 = (pre[nchk] > 15) ? 15 : pre[nchk];
      chk("u8 bdp", int'({busy8, done8, pass8}),
          ebusy * 4 + edone * 2 + epass);
      chk("u4 bdp", int'({busy4, done4, pass4}),
          ebusy * 4 + edone * 2 + epass);
      chk("u8 err", int'(err8), e8);
      chk("u4 err", int'(err4), e4);
      chk("u8 ops", int'({a8, b8, ci8}), ev);
      chk("u4 ops", int'({a4, b4, ci4}), ev);
      chk("u8 fail_vec", int'(fv8), efv);
      chk("u8 fail_obs", int'(fo8), efo);
      chk("u4 fail_vec", int'(fv4), efv);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_mode(int m);
    bit mm;
    int ex;
    rst = 1'b1;
    tick();
    fmode = m;
    for (int k = 0; k < N; k++) begin
      rnd_bad[k] = ($urandom_range(0, 15) == 0);
      rnd_x[k] = 5'($urandom_range(1, 31));
    end
    pre[0] = 0;
    first_bad = -1;
    for (int k = 0; k < N; k++) begin
      ex = ((k >> 5) & 15) + ((k >> 1) & 15) + (k & 1);
      mm = (adder(m, k) != 5'(ex));
      pre[k+1] = pre[k] + int'(mm);
      if (mm && first_bad < 0) first_bad = k;
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic run_wait(input int poke, output int cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start taken", int'({busy8, done8}), 2);
    cyc = 0;
    while (!done8 && cyc < T + 1000) begin
      start = (cyc == poke);
      tick();
      cyc++;
    end
    start = 1'b0;
  endtask

  initial begin
    int c, n0;
    tick();
    // 1: good adder, latency and pass
    set_mode(0);
    chk("model good", pre[N], 0);
    run_wait(-1, c);
    chk("latency", c, 2048);
    chk("pass good", int'(pass8), 1);
    chk("err good", int'(err8), 0);
    // 6: start in DONE restarts; start mid-run ignored
    run_wait(50, c);
    chk("latency poke", c, 2048);
    chk("pass poke", int'(pass8), 1);
    // 2: sum[0] stuck-at-0
    set_mode(1);
    chk("model sa0 cnt", pre[N], 256);
    chk("model sa0 first", first_bad, 1);
    chk("model sa0 obs", int'(adder(1, 1)), 0);
    run_wait(-1, c);
    chk("sa0 err8", int'(err8), 255);
    chk("sa0 pass", int'(pass8), 0);
`ifdef RCA_CHK_FIRST_FAIL_EN
    chk("sa0 fail_vec", int'(fv8), 9'h001);
    chk("sa0 fail_obs", int'(fo8), 5'h00);
`endif
    // 3: carry-out stuck-at-0
    set_mode(2);
    n0 = 0;
    for (int k = 0; k < N; k += 2)
      if (adder(2, k) != adder(0, k)) n0++;
    chk("model co c0", n0, 120);
    chk("model co cnt", pre[N], 256);
    run_wait(-1, c);
    chk("co err8", int'(err8), 255);
    chk("co pass", int'(pass8), 0);
    // 4: inverted sum, small counter saturates
    set_mode(3);
    chk("model inv cnt", pre[N], 512);
    run_wait(-1, c);
    chk("inv err4", int'(err4), 15);
    chk("inv done4", int'(done4), 1);
    chk("inv pass4", int'(pass4), 0);
    // 5: reset mid-run, then fresh run
    set_mode(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 * P + 1; i++) tick();
    chk("mid busy", int'(busy8), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst zero", int'({busy8, done8, pass8, err8,
                          a8, b8, ci8}), 0);
    run_wait(-1, c);
    chk("after rst pass", int'(pass8), 1);
    // rst wins over start
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("rst prio", int'({busy8, done8}), 0);
    // random faults
    set_mode(4);
    run_wait(-1, c);
    chk("rnd latency", c, 2048);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
